// File: rtl/select_pkg.sv
// Shared types and helpers for the push-button selection counter and the mode/menu mux.
package select_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN,
    STEP_LOAD
  } step_e;

  // Limit an externally supplied index to the last legal position n-1.
  function automatic int unsigned sel_clamp(input int unsigned value, input int unsigned n);
    return (value >= n) ? (n - 1) : value;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button front end: synchroniser, optional debounce filter (SELECT_COUNTER_DEBOUNCE_EN), rising-edge detector.
module btn_edge
  import select_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("btn_edge: DEBOUNCE_CYCLES out of range");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync2;
  logic                   level;
  logic                   level_d;
  logic                   primed;
  logic                   armed;

  assign sync2 = sync[SYNC_STAGES-1];

  // Edges are only honoured once a genuine low sample has been seen since reset,
  // so a button held through reset release never counts as a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      level_d <= 1'b0;
      primed  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], raw};
      level_d <= level;
      primed  <= 1'b1;
      armed   <= armed | (primed & ~sync[0]);
    end
  end

`ifdef SELECT_COUNTER_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt;
  logic            filt;

  // The filtered level follows sync2 only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      filt   <= 1'b0;
    end else if (sync2 == filt) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      filt   <= sync2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  assign rise = level & ~level_d & armed;

endmodule

// File: rtl/select_counter.sv
// Modulo-N / saturating selection index driven by two push-buttons, with parallel load and status pulses.
// Debounce filtering in the button front ends is enabled by defining SELECT_COUNTER_DEBOUNCE_EN.
module select_counter
  import select_pkg::*;
#(
  parameter int N               = 4,
  parameter int CNT_W           = $clog2(N),
  parameter int SATURATE        = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             next_in,
  input  logic             prev_in,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             changed,
  output logic             wrapped,
  output logic             at_limit
);

  if (N < 2 || N > 256) begin : g_bad_n
    $error("select_counter: N out of range");
  end

  logic       next_rise;
  logic       prev_rise;
  step_e      step;
  logic [CNT_W:0]   up_val;
  logic [CNT_W-1:0] nxt_count;
  logic       nxt_wrap;
  logic       nxt_block;
  logic       nxt_accept;

  btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .reset (reset),
    .raw   (next_in),
    .rise  (next_rise)
  );

  btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk   (clk),
    .reset (reset),
    .raw   (prev_in),
    .rise  (prev_rise)
  );

  // Load beats any button edge; simultaneous up and down presses cancel.
  always_comb begin
    step = STEP_NONE;
    if (load)
      step = STEP_LOAD;
    else if (next_rise && !prev_rise)
      step = STEP_UP;
    else if (prev_rise && !next_rise)
      step = STEP_DOWN;
  end

  // Increment is formed one bit wider and compared with N so non-power-of-two N never overshoots.
  always_comb begin
    up_val     = {1'b0, count} + (CNT_W+1)'(1);
    nxt_count  = count;
    nxt_wrap   = 1'b0;
    nxt_block  = 1'b0;
    nxt_accept = 1'b0;
    case (step)
      STEP_LOAD: begin
        nxt_count  = CNT_W'(sel_clamp(32'(load_value), 32'(N)));
        nxt_accept = 1'b1;
      end
      STEP_UP: begin
        if (up_val == (CNT_W+1)'(N)) begin
          if (SATURATE != 0) begin
            nxt_block = 1'b1;
          end else begin
            nxt_count  = '0;
            nxt_wrap   = 1'b1;
            nxt_accept = 1'b1;
          end
        end else begin
          nxt_count  = up_val[CNT_W-1:0];
          nxt_accept = 1'b1;
        end
      end
      STEP_DOWN: begin
        if (count == '0) begin
          if (SATURATE != 0) begin
            nxt_block = 1'b1;
          end else begin
            nxt_count  = CNT_W'(N - 1);
            nxt_wrap   = 1'b1;
            nxt_accept = 1'b1;
          end
        end else begin
          nxt_count  = count - CNT_W'(1);
          nxt_accept = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      changed  <= 1'b0;
      wrapped  <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      count   <= nxt_count;
      changed <= (nxt_count != count);
      wrapped <= nxt_wrap;
      if (nxt_block)
        at_limit <= 1'b1;
      else if (nxt_accept)
        at_limit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_select_counter.sv
// Directed bench for select_counter: wrap (N=4) and saturate (N=5) instances share the same button stimulus.
module tb_select_counter;

`ifdef SELECT_COUNTER_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = 2 + DB;

  logic       clk = 1'b0;
  logic       reset;
  logic       next_in;
  logic       prev_in;
  logic       load;
  logic [1:0] lvA;
  logic [2:0] lvB;
  logic [1:0] countA;
  logic [2:0] countB;
  logic       changedA, wrappedA, atLimitA;
  logic       changedB, wrappedB, atLimitB;

  int vectors    = 0;
  int miscompares = 0;
  int curA = 0;
  int curB = 0;

  always #5 clk = ~clk;

  select_counter #(.N(4), .SATURATE(0), .DEBOUNCE_CYCLES(16)) dutA (
    .clk(clk), .reset(reset), .next_in(next_in), .prev_in(prev_in),
    .load(load), .load_value(lvA), .count(countA),
    .changed(changedA), .wrapped(wrappedA), .at_limit(atLimitA)
  );

  select_counter #(.N(5), .SATURATE(1), .DEBOUNCE_CYCLES(16)) dutB (
    .clk(clk), .reset(reset), .next_in(next_in), .prev_in(prev_in),
    .load(load), .load_value(lvB), .count(countB),
    .changed(changedB), .wrapped(wrappedB), .at_limit(atLimitB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " countA"}, 32'(countA), 32'(curA));
    checkOutput({tag, " countB"}, 32'(countB), 32'(curB));
    checkOutput({tag, " changedA"}, 32'(changedA), 0);
    checkOutput({tag, " changedB"}, 32'(changedB), 0);
    checkOutput({tag, " wrappedA"}, 32'(wrappedA), 0);
  endtask

  // One press of the given button pattern; checks latency, the update and the pulse width.
  task automatic applyStimulus(input string tag, input logic n, input logic p,
                               input int newA, input int wA, input int newB, input int limB);
    next_in = n;
    prev_in = p;
    repeat (LAT) @(negedge clk);
    checkIdle({tag, " pre"});
    @(negedge clk);
    checkOutput({tag, " countA"}, 32'(countA), 32'(newA));
    checkOutput({tag, " changedA"}, 32'(changedA), 32'(newA != curA));
    checkOutput({tag, " wrappedA"}, 32'(wrappedA), 32'(wA));
    checkOutput({tag, " atLimitA"}, 32'(atLimitA), 0);
    checkOutput({tag, " countB"}, 32'(countB), 32'(newB));
    checkOutput({tag, " changedB"}, 32'(changedB), 32'(newB != curB));
    checkOutput({tag, " wrappedB"}, 32'(wrappedB), 0);
    checkOutput({tag, " atLimitB"}, 32'(atLimitB), 32'(limB));
    curA = newA;
    curB = newB;
    next_in = 1'b0;
    prev_in = 1'b0;
    @(negedge clk);
    checkIdle({tag, " post"});
    repeat (2 + DB) @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    next_in = 1'b0;
    prev_in = 1'b0;
    load    = 1'b0;
    lvA     = '0;
    lvB     = '0;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    checkOutput("reset atLimitB", 32'(atLimitB), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    applyStimulus("s1 prev",  1'b0, 1'b1, 3, 1, 0, 1);
    applyStimulus("s2 next",  1'b1, 1'b0, 0, 1, 1, 0);
    applyStimulus("s3 next",  1'b1, 1'b0, 1, 0, 2, 0);
    applyStimulus("s4 next",  1'b1, 1'b0, 2, 0, 3, 0);
    applyStimulus("s5 next",  1'b1, 1'b0, 3, 0, 4, 0);
    applyStimulus("s6 next",  1'b1, 1'b0, 0, 1, 4, 1);
    applyStimulus("s7 prev",  1'b0, 1'b1, 3, 1, 3, 0);
    applyStimulus("s8 prev",  1'b0, 1'b1, 2, 0, 2, 0);
    applyStimulus("s9 both",  1'b1, 1'b1, 2, 0, 2, 0);

    // Load coincides with the cycle the next edge is presented; the edge must be dropped.
    next_in = 1'b1;
    repeat (LAT) @(negedge clk);
    load = 1'b1;
    lvA  = 2'd1;
    lvB  = 3'd7;
    @(negedge clk);
    load = 1'b0;
    checkOutput("load1 countA", 32'(countA), 1);
    checkOutput("load1 changedA", 32'(changedA), 1);
    checkOutput("load1 countB", 32'(countB), 4);
    checkOutput("load1 changedB", 32'(changedB), 1);
    curA = 1;
    curB = 4;
    next_in = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    checkIdle("load1 after");

    applyStimulus("s10 next", 1'b1, 1'b0, 2, 0, 4, 1);

    // Same-value load: no change pulse, but it clears the saturation flag.
    load = 1'b1;
    lvA  = 2'd2;
    lvB  = 3'd6;
    @(negedge clk);
    load = 1'b0;
    checkIdle("load2");
    checkOutput("load2 atLimitB", 32'(atLimitB), 0);

    // Held button: exactly one step.
    next_in = 1'b1;
    repeat (LAT) @(negedge clk);
    checkIdle("hold pre");
    @(negedge clk);
    checkOutput("hold countA", 32'(countA), 3);
    checkOutput("hold changedA", 32'(changedA), 1);
    checkOutput("hold atLimitB", 32'(atLimitB), 1);
    curA = 3;
    repeat (48) @(negedge clk);
    checkIdle("hold end");
    next_in = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    checkIdle("hold release");

    // Asynchronous reset while a press sits in the synchroniser, button kept high afterwards.
    next_in = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    curA = 0;
    curB = 0;
    checkIdle("areset");
    checkOutput("areset atLimitB", 32'(atLimitB), 0);
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (10 + DB) @(negedge clk);
    checkIdle("areset held");
    next_in = 1'b0;
    repeat (4 + DB) @(negedge clk);
    applyStimulus("s11 next", 1'b1, 1'b0, 1, 0, 1, 0);

`ifdef SELECT_COUNTER_DEBOUNCE_EN
    next_in = 1'b1;
    repeat (10) @(negedge clk);
    next_in = 1'b0;
    repeat (2 * DB) @(negedge clk);
    checkIdle("glitch");
    applyStimulus("s12 next", 1'b1, 1'b0, 2, 0, 2, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/select_counter.md
Name: select_counter

Overview:
- Parametrised, fully synchronous successor to the team's push-button selection counter.
- Two raw asynchronous button inputs, `next_in` and `prev_in`, are synchronised and edge-detected on the system clock.
- Each detected press steps a modulo-N (or saturating) selection index up or down.
- Sits between the board push-buttons and the mode/menu mux logic. Also gives a parallel load path and single-cycle status pulses.

Parameters:
- N, 4, number of selectable positions; legal range 2..256.
- CNT_W, $clog2(N), width of count; derived, not overridden.
- SATURATE, 0, 0 = wrap at the ends, 1 = hold at 0 / N-1.
- DEBOUNCE_CYCLES, 16, stable-input clocks required when DEBOUNCE_EN is defined; legal range 2..65535.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  reset, asynchronous, active-high.
- next_in  in  1  raw button input; a rising edge requests +1.
- prev_in  in  1  raw button input; a rising edge requests -1.
- load  in  1  synchronous load strobe.
- load_value  in  CNT_W  value to load; values >= N clamp to N-1.
- count  out  CNT_W  current selection index.
- changed  out  1  one-cycle pulse whenever count changes value.
- wrapped  out  1  one-cycle pulse when a step crosses N-1->0 or 0->N-1 (wrap mode only).
- at_limit  out  1  level: high when a step was blocked by saturation; clears on the next accepted step or load.

Behaviour:
- Reset, any time including mid-operation:
  - count=0, changed=0, wrapped=0, at_limit=0.
  - Synchroniser and edge-history flops cleared to 0.
  - A button held high through reset release produces no step.
- Synchroniser: two flops per button input.
- Edge detect: pulse = sync2 & ~sync2_d.
- Latency: if edge k is the first clock edge that samples the input high, count updates at edge k+2.
- Priority per clock, highest first: reset, load, step.
  - load=1: count <= min(load_value, N-1). Edges seen that cycle are discarded. changed pulses only if the value differs.
  - Next edge only: count+1.
  - Prev edge only: count-1.
  - Both edges in the same cycle: no change, no pulses.
- Wrap mode (SATURATE=0):
  - count=N-1 plus next gives 0, with wrapped=1 and changed=1.
  - count=0 plus prev gives N-1, with wrapped=1 and changed=1.
- Saturate mode (SATURATE=1):
  - A step past an end leaves count unchanged, changed=0, at_limit=1.
  - wrapped is tied to 0.
- Arithmetic: computed at CNT_W+1 bits and then compared against N, so non-power-of-two N never reaches the illegal values N..2^CNT_W-1.
- Pulses: changed and wrapped are registered, high for exactly one clock, aligned with the count update.
- Held button: exactly one step per press. No auto-repeat.
- Minimum press spacing: 2 clocks high and 2 clocks low per button. Faster toggling is not guaranteed to be counted.

Optional Feature:
- Macro: SELECT_COUNTER_DEBOUNCE_EN.
- Defined:
  - A debounce filter is inserted after each synchroniser.
  - A per-input counter of width $clog2(DEBOUNCE_CYCLES+1) restarts on every change of sync2.
  - The filtered level flips only after DEBOUNCE_CYCLES consecutive equal samples.
  - Edge detect operates on the filtered level.
  - Latency becomes k+2+DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES produce no step.
  - Reset clears the filter counters and filtered levels to 0.
- Undefined: the filter logic is absent and latency is k+2.

Decomposition:
- Package select_pkg holds:
  - Localparam SYNC_STAGES=2.
  - Enum step_e {STEP_NONE, STEP_UP, STEP_DOWN, STEP_LOAD}, used by the next-state logic.
  - Function sel_clamp(value, n), shared with the mux logic.
- Sub-module btn_edge:
  - Contents: synchroniser, optional debounce, rising-edge detector.
  - Ports: clk, reset, raw, rise.
  - Instantiated twice, once per button.
- Top level holds the step decode, the count register and the status flags.

Test Plan:
- N=4, SATURATE=0: four next presses from reset -> count 1,2,3,0. wrapped pulses once, on the 3->0 update. changed pulses 4 times.
- N=5, SATURATE=1: prev press at count 0 -> count stays 0, at_limit=1, changed=0. Then a next press -> count 1, at_limit=0.
- next_in and prev_in rise on the same clock at count 2 -> count stays 2 and no pulses. load_value=7 with N=5 and load=1 together with a next edge -> count 4.
- next_in held high for 50 clocks -> exactly one increment. It appears 2 clocks after the first sampling edge (2+DEBOUNCE_CYCLES clocks with debounce).
- reset asserted asynchronously between clock edges while count=3 and a press is in the synchroniser -> count=0 immediately, no step after release even though the button stays high.
- With SELECT_COUNTER_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-clock glitch on next_in -> no change. A 20-clock press -> one increment at the expected latency.
